// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the AXI4-Lite memory responder.
package mem_resp_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } state_e;

    typedef enum logic {
        RD,
        WR
    } prio_e;

    function automatic logic [1:0] resp_code(input logic in_range);
        return in_range ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_lite_mem_responder_if.sv
// AXI4-Lite read/write channel bundle between an initiator and the memory responder.
interface axi_lite_mem_responder_if #(
    parameter int unsigned ADDR_W = 64
);
    import mem_resp_pkg::*;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/sram_resp_bank.sv
// DEPTH x 64 word array: byte-enabled synchronous write, 1-cycle synchronous read.
module sram_resp_bank
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (wr_en && wr_strb[i]) begin
                mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Output register doubles as the bus rdata: held until the next read or clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end else if (rd_clr) begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite memory responder: one outstanding transaction, programmable response latency.
module axi_lite_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned       DEPTH     = 4096,
    parameter int unsigned       RD_LAT    = 2,
    parameter int unsigned       WR_LAT    = 1
) (
    input logic                     clk,
    input logic                     rst,
    axi_lite_mem_responder_if.slave bus
);

    localparam int unsigned       IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   BASE_EXT = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0]   LIMIT    = BASE_EXT + (ADDR_W+1)'(DEPTH * 8);

    state_e            state;
    prio_e             prio;
    logic [CNT_W-1:0]  cnt;
    logic              rvalid_q;
    logic              bvalid_q;
    logic [1:0]        rresp_q;
    logic [1:0]        bresp_q;
    logic [IDX_W-1:0]  idx_q;
    logic              in_range_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              wr_req;
    logic              ar_acc;
    logic              aw_acc;
    logic              expire;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_in_range;
    logic [IDX_W-1:0]  acc_idx;
    logic              rd_en;
    logic              rd_clr;
    logic              wr_en;

    assign wr_req = bus.awvalid & bus.wvalid;
    assign ar_acc = (state == IDLE) & bus.arvalid & ((prio == RD) | ~wr_req);
    assign aw_acc = (state == IDLE) & wr_req & ((prio == WR) | ~bus.arvalid);

    assign bus.arready = ar_acc;
    assign bus.awready = aw_acc;
    assign bus.wready  = aw_acc;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;

    // Extend by one bit so BASE_ADDR + 8*DEPTH cannot wrap at the top of the address space.
    assign acc_addr     = ar_acc ? bus.araddr : bus.awaddr;
    assign acc_in_range = ({1'b0, acc_addr} >= BASE_EXT) && ({1'b0, acc_addr} < LIMIT);
    assign acc_idx      = IDX_W'((acc_addr - BASE_ADDR) >> 3);

    assign expire = (cnt == '0);
    assign rd_en  = (state == RD_WAIT) & expire & in_range_q;
    assign rd_clr = (state == RD_WAIT) & expire & ~in_range_q;
    // No commit on a reset edge, since that transaction's response is being dropped.
    assign wr_en  = (state == WR_WAIT) & expire & in_range_q & ~rst;

    always_ff @(posedge clk) begin
        if (ar_acc | aw_acc) begin
            idx_q      <= acc_idx;
            in_range_q <= acc_in_range;
        end
        if (aw_acc) begin
            wdata_q <= bus.wdata;
            wstrb_q <= bus.wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= RD;
            cnt      <= '0;
            rvalid_q <= 1'b0;
            bvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            bresp_q  <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_acc) begin
                        state <= RD_WAIT;
                        cnt   <= CNT_W'(RD_LAT - 1);
                        prio  <= WR;
                    end else if (aw_acc) begin
                        state <= WR_WAIT;
                        cnt   <= CNT_W'(WR_LAT - 1);
                        prio  <= RD;
                    end
                end
                RD_WAIT: begin
                    if (expire) begin
                        state    <= RD_RESP;
                        rvalid_q <= 1'b1;
                        rresp_q  <= resp_code(in_range_q);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (expire) begin
                        state    <= WR_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= resp_code(in_range_q);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RD_RESP: begin
                    if (bus.rready) begin
                        state    <= IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                WR_RESP: begin
                    if (bus.bready) begin
                        state    <= IDLE;
                        bvalid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sram_resp_bank #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_en),
        .rd_clr  (rd_clr),
        .rd_idx  (idx_q),
        .rd_data (bus.rdata),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_data (wdata_q),
        .wr_strb (wstrb_q)
    );

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed scoreboard bench for axi_lite_mem_responder.
module tb_axi_lite_mem_responder;
    import mem_resp_pkg::*;

    localparam logic [63:0] BASE   = 64'h8000_0000;
    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned WR_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_mem_responder_if #(.ADDR_W(64)) bus ();

    axi_lite_mem_responder #(
        .ADDR_W    (64),
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .RD_LAT    (RD_LAT),
        .WR_LAT    (WR_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [65:0] rd_sb[$];
    logic [1:0]  wr_sb[$];
    logic [7:0]  order[$];
    int          both_cnt;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_ar(input logic [63:0] addr);
        @(negedge clk);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (bus.arready) break;
            @(negedge clk);
        end
        check("ar_accept", {65'd0, bus.arready}, 66'd1);
        @(posedge clk);
        #1 bus.arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [63:0] addr, input logic [63:0] data,
                           input logic [7:0] strb);
        @(negedge clk);
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (bus.awready) break;
            @(negedge clk);
        end
        check("aw_accept", {64'd0, bus.awready, bus.wready}, 66'd3);
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    // Entered 1 time unit after the acceptance edge.
    task automatic wait_r(input int hold, input string tag);
        logic [65:0] exp;
        int lat;
        bus.rready = (hold == 0);
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus.rvalid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_rvalid"}, {65'd0, bus.rvalid}, 66'd1);
        check({tag, "_lat"}, 66'(lat), 66'(RD_LAT));
        exp = (rd_sb.size() > 0) ? rd_sb.pop_front() : 'x;
        check({tag, "_data"}, {bus.rresp, bus.rdata}, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold"}, {bus.rvalid, bus.rresp[0], bus.rdata}, {1'b1, exp[64], exp[63:0]});
        end
        bus.rready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_drop"}, {65'd0, bus.rvalid}, 66'd0);
    endtask

    task automatic wait_b(input string tag);
        logic [1:0] exp;
        int lat;
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus.bvalid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_bvalid"}, {65'd0, bus.bvalid}, 66'd1);
        check({tag, "_lat"}, 66'(lat), 66'(WR_LAT));
        exp = (wr_sb.size() > 0) ? wr_sb.pop_front() : 'x;
        check({tag, "_bresp"}, {64'd0, bus.bresp}, {64'd0, exp});
        @(posedge clk);
        #1;
        check({tag, "_drop"}, {65'd0, bus.bvalid}, 66'd0);
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [63:0] data,
                           input logic [1:0] resp, input int hold, input string tag);
        rd_sb.push_back({resp, data});
        send_ar(addr);
        wait_r(hold, tag);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input logic [1:0] resp, input string tag);
        wr_sb.push_back(resp);
        send_aw(addr, data, strb);
        wait_b(tag);
    endtask

    initial begin
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valids", {64'd0, bus.rvalid, bus.bvalid}, 66'd0);
        check("rst_rdata", {bus.rresp, bus.rdata}, 66'd0);
        check("rst_bresp", {64'd0, bus.bresp}, 66'd0);

        do_write(BASE, 64'h1122_3344_5566_7788, 8'hFF, RESP_OKAY, "w0");
        do_read(BASE, 64'h1122_3344_5566_7788, RESP_OKAY, 0, "r0");

        do_write(BASE + 8, 64'h0, 8'hFF, RESP_OKAY, "w1_clr");
        do_write(BASE + 8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, RESP_OKAY, "w1_strb");
        do_read(BASE + 8, 64'h0000_0000_FFFF_FFFF, RESP_OKAY, 0, "r1_strb");
        do_write(BASE + 8, 64'hA5A5_A5A5_A5A5_A5A5, 8'h00, RESP_OKAY, "w1_nostrb");
        do_read(BASE + 8, 64'h0000_0000_FFFF_FFFF, RESP_OKAY, 0, "r1_nostrb");

        // Backpressure, then arready must be back on the cycle after the handshake.
        do_read(BASE, 64'h1122_3344_5566_7788, RESP_OKAY, 3, "r_bp");
        bus.araddr  = BASE + 8;
        bus.arvalid = 1'b1;
        #1;
        check("bp_arready", {65'd0, bus.arready}, 66'd1);
        rd_sb.push_back({RESP_OKAY, 64'h0000_0000_FFFF_FFFF});
        @(posedge clk);
        #1 bus.arvalid = 1'b0;
        wait_r(0, "r_after_bp");

        do_read(64'h7FFF_FFF8, 64'h0, RESP_SLVERR, 0, "r_oor_lo");
        do_write(BASE + 8 * DEPTH - 8, 64'hCAFE_0000_BEEF_0001, 8'hFF, RESP_OKAY, "w_last");
        do_read(BASE + 8 * DEPTH - 8, 64'hCAFE_0000_BEEF_0001, RESP_OKAY, 0, "r_last");
        do_write(BASE + 8 * DEPTH, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, RESP_SLVERR, "w_oor_hi");
        do_read(BASE, 64'h1122_3344_5566_7788, RESP_OKAY, 0, "r_after_oor");
        do_read(BASE + 8 * DEPTH, 64'h0, RESP_SLVERR, 0, "r_oor_hi");

        // Reset while the read is in its wait state.
        send_ar(BASE);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.araddr  = BASE + 8;
        bus.arvalid = 1'b1;
        #1;
        check("mid_rst_rvalid", {65'd0, bus.rvalid}, 66'd0);
        check("mid_rst_arready", {65'd0, bus.arready}, 66'd1);
        rd_sb.push_back({RESP_OKAY, 64'h0000_0000_FFFF_FFFF});
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        check("mid_rst_no_resp", {65'd0, bus.rvalid}, 66'd0);
        wait_r(0, "r_post_rst");

        // Competing requests held from reset: accepts must alternate R, W, R, W...
        @(negedge clk);
        rst         = 1'b1;
        bus.araddr  = BASE;
        bus.arvalid = 1'b1;
        bus.awaddr  = BASE + 16;
        bus.wdata   = 64'h0000_0000_0000_0055;
        bus.wstrb   = 8'hFF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.rready  = 1'b1;
        bus.bready  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        both_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (bus.arready && bus.awready) both_cnt++;
            if (bus.arready) order.push_back("R");
            if (bus.awready) order.push_back("W");
            @(negedge clk);
        end
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("sim_both_ready", 66'(both_cnt), 66'd0);
        check("sim_accepts", {65'd0, order.size() >= 4}, 66'd1);
        for (int i = 0; i < order.size(); i++) begin
            check("sim_order", {58'd0, order[i]}, {58'd0, (i % 2 == 1) ? 8'h57 : 8'h52});
        end
        repeat (6) @(posedge clk);
        #1;
        do_read(BASE + 16, 64'h0000_0000_0000_0055, RESP_OKAY, 0, "r_sim_data");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
